cve2_perf_counters: RTL and testbench
=====================================

# cve2_perf_counters

Machine counter/timer unit for the core. It holds mcycle, minstret, the configurable mhpmcounter3..N with their mhpmevent selectors, and mcountinhibit. It serves reads and writes from the CSR access path in the ID/EX stage, addressed by `csr_num_e` and operated on by `csr_op_e`. It counts cycles, retired instructions and microarchitectural events supplied by the surrounding pipeline.

## Interface
Parameters:
- `MHPMCounterNum`, 2: number of implemented mhpmcounters (0..10), starting at index 3.
- `MHPMCounterWidth`, 40: width of each mhpmcounter (32..64); mcycle and minstret are always 64 bits.

Ports:
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `csr_access_i`  in  1  CSR instruction present this cycle.
- `csr_addr_i`  in  12  CSR address (`csr_num_e`).
- `csr_op_i`  in  2  `csr_op_e`.
- `csr_wdata_i`  in  32  CSR write operand.
- `csr_op_en_i`  in  1  commit strobe; the instruction is not killed.
- `csr_rdata_o`  out  32  combinational read data.
- `csr_hit_o`  out  1  address belongs to this block.
- `stop_count_i`  in  1  debug stopcount; freezes all counters.
- `instr_ret_i`  in  1  one instruction retired this cycle.
- `hpm_events_i`  in  10  `hpm_event_t` event strobes.

## Operation
- Hit set:
  - mcountinhibit
  - mhpmevent3..31
  - mcycle[h], minstret[h]
  - mhpmcounter3..31[h]
- Write enable = `csr_access_i & csr_op_en_i & csr_hit_o & (csr_op_i != CSR_OP_READ)`.
- New value by operation, where old = current 32-bit view:
  - WRITE: `wdata`.
  - SET: `old | wdata`.
  - CLEAR: `old & ~wdata`.
- Low-half address writes bits [31:0]; the upper bits are kept. High-half (`h`) address writes bits [63:32]; the lower bits are kept.
- mcycle increments every cycle when `!mcountinhibit[0] & !stop_count_i`.
- minstret increments when `instr_ret_i & !mcountinhibit[2] & !stop_count_i`.
- mhpmcounterK increments when `|(hpm_events_i & mhpmeventK[9:0]) & !mcountinhibit[K] & !stop_count_i`. Increment is at most 1 per cycle.
- Write beats increment in the same cycle: the written value is stored with no +1 applied, for both halves.
- Counters wrap from all-ones to 0. The carry from bit 31 to bit 32 is applied in the same cycle.
- Width rules for mhpmcounters:
  - bits >= `MHPMCounterWidth` read 0 and ignore writes;
  - the high-half read returns bits [W-1:32], zero-extended, or 0 when W = 32.
- Unimplemented mhpmcounterK/mhpmeventK (K >= 3+`MHPMCounterNum`): hit = 1, read 0, writes ignored.
- mhpmeventK stores bits [9:0] only; the upper bits read 0.
- mcountinhibit bit 1 and bits >= 3+`MHPMCounterNum` are hard-wired 0.
- Non-hit address: `csr_rdata_o` = 0.

## Timing
- Reset value of every register is 0. After reset, `csr_rdata_o` = 0 for every address until counting starts.
- Read: same cycle, combinational from `csr_addr_i`, returns the pre-update value.
- Write at cycle t is visible at t+1.
- mcycle written to X at t reads X at t+1 and X+1 at t+2 (if not inhibited).
- Inhibit bit written at t stops counting from t+1. The increment at t still uses the old inhibit.
- `stop_count_i` acts in the same cycle.
- Asserting `rst_ni` mid-operation clears all state immediately. There is no pending-write state.

## Structure
- Shared package additions:
  - `hpm_event_t` (10-bit packed);
  - event index constants:
    - `HPM_EVT_LOAD_WAIT`=0, `STORE_WAIT`=1, `JUMP`=2, `BRANCH`=3, `BRANCH_TAKEN`=4;
    - `MUL_WAIT`=5, `DIV_WAIT`=6, `FETCH_WAIT`=7, `LOAD`=8, `STORE`=9;
  - `CSR_MCOUNTINHIBIT` bit constants.
- Sub-module `cve2_counter`: one counter with parameter `CounterWidth` and inputs inc, we_lo, we_hi, wdata. Instantiated for mcycle, for minstret and once per implemented mhpmcounter.

## Test plan
- mcycle basic: reset, release, wait 5 cycles, read CSR_MCYCLE → 5; read CSR_MCYCLEH → 0.
- Carry: write mcycle = 0xFFFFFFFF and mcycleh = 0.
  - Two cycles later, the low read returns 0x00000000 and mcycleh returns 1.
- Write priority: issue a CSRRW write of mcycle = 0x100 while counting.
  - Reads return 0x100 at t+1 and 0x101 at t+2.
- Inhibit and SET/CLEAR: CSRRS mcountinhibit 0x5 → mcycle and minstret frozen over 10 cycles with `instr_ret_i`=1.
  - CSRRC 0x4 → minstret counts again and mcycle stays frozen.
- HPM width: `MHPMCounterWidth`=40, mhpmevent3 = 1<<2, pulse JUMP 3 times → mhpmcounter3 = 3.
  - Write mhpmcounter3h = 0xFFFFFFFF → reads 0xFF.
- Unimplemented and stop: read mhpmcounter7 with `MHPMCounterNum`=2 → hit = 1, data 0.
  - `stop_count_i` = 1 for 4 cycles → mcycle unchanged.

Source files
------------

// File: rtl/cve2_perf_counters_pkg.sv
// Shared types for the machine counter/timer unit:
// CSR numbers and ops, HPM event strobes, mcountinhibit bits.
package cve2_perf_counters_pkg;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic [11:0] {
        CSR_MCOUNTINHIBIT = 12'h320,
        CSR_MHPMEVENT3    = 12'h323,
        CSR_MHPMEVENT31   = 12'h33F,
        CSR_MCYCLE        = 12'hB00,
        CSR_MINSTRET      = 12'hB02,
        CSR_MHPMCOUNTER3  = 12'hB03,
        CSR_MHPMCOUNTER7  = 12'hB07,
        CSR_MHPMCOUNTER31 = 12'hB1F,
        CSR_MCYCLEH       = 12'hB80,
        CSR_MINSTRETH     = 12'hB82,
        CSR_MHPMCOUNTER3H = 12'hB83,
        CSR_MHPMCOUNTER31H = 12'hB9F
    } csr_num_e;

    // 32-entry CSR pages (addr[11:5]) served by this unit
    localparam logic [6:0] CSR_PAGE_EVT    = 7'h19;
    localparam logic [6:0] CSR_PAGE_CNT_LO = 7'h58;
    localparam logic [6:0] CSR_PAGE_CNT_HI = 7'h5C;

    localparam int unsigned HPM_EVT_NUM = 10;
    typedef logic [HPM_EVT_NUM-1:0] hpm_event_t;

    localparam int unsigned HPM_EVT_LOAD_WAIT    = 0;
    localparam int unsigned HPM_EVT_STORE_WAIT   = 1;
    localparam int unsigned HPM_EVT_JUMP         = 2;
    localparam int unsigned HPM_EVT_BRANCH       = 3;
    localparam int unsigned HPM_EVT_BRANCH_TAKEN = 4;
    localparam int unsigned HPM_EVT_MUL_WAIT     = 5;
    localparam int unsigned HPM_EVT_DIV_WAIT     = 6;
    localparam int unsigned HPM_EVT_FETCH_WAIT   = 7;
    localparam int unsigned HPM_EVT_LOAD         = 8;
    localparam int unsigned HPM_EVT_STORE        = 9;

    // mcountinhibit bit positions
    localparam int unsigned MCNTINH_CY   = 0;
    localparam int unsigned MCNTINH_IR   = 2;
    localparam int unsigned MCNTINH_HPM0 = 3;

    function automatic logic [31:0] csr_apply(
        input csr_op_e     op,
        input logic [31:0] old,
        input logic [31:0] wdata
    );
        logic [31:0] res;
        res = old;
        unique case (op)
            CSR_OP_WRITE: res = wdata;
            CSR_OP_SET:   res = old | wdata;
            CSR_OP_CLEAR: res = old & ~wdata;
            default:      res = old;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cve2_perf_counters_if.sv
// CSR access path between the ID/EX stage (master) and the
// counter unit (slave): address/op/data in, read data and hit out.
interface cve2_perf_counters_if ();
    import cve2_perf_counters_pkg::*;

    logic        csr_access_i;
    logic [11:0] csr_addr_i;
    csr_op_e     csr_op_i;
    logic [31:0] csr_wdata_i;
    logic        csr_op_en_i;
    logic [31:0] csr_rdata_o;
    logic        csr_hit_o;

    modport master (
        output csr_access_i, csr_addr_i, csr_op_i,
        output csr_wdata_i, csr_op_en_i,
        input  csr_rdata_o, csr_hit_o
    );

    modport slave (
        input  csr_access_i, csr_addr_i, csr_op_i,
        input  csr_wdata_i, csr_op_en_i,
        output csr_rdata_o, csr_hit_o
    );
endinterface

// File: rtl/cve2_perf_counters_counter.sv
// One counter of CounterWidth bits with 32-bit half writes.
// Ports: clk_i/rst_ni, i_inc, i_we_lo/i_we_hi, i_wdata, o_val (0-ext 64).
module cve2_counter #(
    parameter int unsigned CounterWidth = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_inc,
    input  logic        i_we_lo,
    input  logic        i_we_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_val
);
    logic [CounterWidth-1:0] r_cnt;
    logic [63:0]             w_ext;
    logic [63:0]             w_wr;

    assign w_ext = 64'(r_cnt);
    assign o_val = w_ext;

    // Merge the written half into the current value; bits above
    // CounterWidth fall away on the store.
    always_comb begin
        w_wr = w_ext;
        if (i_we_lo) w_wr[31:0] = i_wdata;
        if (i_we_hi) w_wr[63:32] = i_wdata;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (i_we_lo || i_we_hi) begin
            r_cnt <= w_wr[CounterWidth-1:0];
        end else if (i_inc) begin
            r_cnt <= r_cnt + CounterWidth'(1);
        end
    end
endmodule

// File: rtl/cve2_perf_counters.sv
// Machine counters: mcycle, minstret, mhpmcounterK, mhpmeventK, mcountinhibit.
// Ports: clk_i/rst_ni, bus (CSR slave), stop_count_i, instr_ret_i, hpm_events_i.
module cve2_perf_counters
    import cve2_perf_counters_pkg::*;
#(
    parameter int unsigned MHPMCounterNum   = 2,
    parameter int unsigned MHPMCounterWidth = 40
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    cve2_perf_counters_if.slave        bus,
    input  logic                       stop_count_i,
    input  logic                       instr_ret_i,
    input  hpm_event_t                 hpm_events_i
);
    localparam int unsigned HpmSz = (MHPMCounterNum > 0) ? MHPMCounterNum : 1;

    localparam logic [31:0] InhMask =
        (32'd1 << MCNTINH_CY) | (32'd1 << MCNTINH_IR) |
        (((32'd1 << MHPMCounterNum) - 32'd1) << MCNTINH_HPM0);

    logic [11:0] w_addr;
    logic [4:0]  w_idx;
    logic [4:0]  w_hidx;
    logic        w_sel_inh;
    logic        w_sel_evt;
    logic        w_sel_lo;
    logic        w_sel_hi;
    logic        w_hit;
    logic        w_we;
    logic [31:0] w_rdata;
    logic [31:0] w_wval;

    logic [31:0] r_inhibit;
    hpm_event_t  r_evt [HpmSz];

    logic [63:0] w_cyc;
    logic [63:0] w_ret;
    logic [63:0] w_hpm_val [HpmSz];
    hpm_event_t  w_evt_sel;
    logic [63:0] w_hpm_sel;

    logic w_inc_cyc;
    logic w_inc_ret;
    logic w_we_cyc_lo;
    logic w_we_cyc_hi;
    logic w_we_ret_lo;
    logic w_we_ret_hi;

    // Address decode
    assign w_addr = bus.csr_addr_i;
    assign w_idx  = w_addr[4:0];
    assign w_hidx = w_idx - 5'd3;

    assign w_sel_inh = (w_addr == CSR_MCOUNTINHIBIT);
    assign w_sel_evt = (w_addr[11:5] == CSR_PAGE_EVT) && (w_idx >= 5'd3);
    assign w_sel_lo  = (w_addr[11:5] == CSR_PAGE_CNT_LO) && (w_idx != 5'd1);
    assign w_sel_hi  = (w_addr[11:5] == CSR_PAGE_CNT_HI) && (w_idx != 5'd1);

    assign w_hit = w_sel_inh | w_sel_evt | w_sel_lo | w_sel_hi;
    assign bus.csr_hit_o = w_hit;

    assign w_we = bus.csr_access_i & bus.csr_op_en_i & w_hit &
                  (bus.csr_op_i != CSR_OP_READ);

    // Pick event selector / counter K; unimplemented K match nothing
    // and read as 0.
    always_comb begin
        w_evt_sel = '0;
        w_hpm_sel = '0;
        for (int k = 0; k < int'(MHPMCounterNum); k++) begin
            if (w_hidx == 5'(k)) begin
                w_evt_sel = r_evt[k];
                w_hpm_sel = w_hpm_val[k];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        unique case (1'b1)
            w_sel_inh: w_rdata = r_inhibit;
            w_sel_evt: w_rdata = 32'(w_evt_sel);
            w_sel_lo: begin
                if (w_idx == 5'd0)      w_rdata = w_cyc[31:0];
                else if (w_idx == 5'd2) w_rdata = w_ret[31:0];
                else                    w_rdata = w_hpm_sel[31:0];
            end
            w_sel_hi: begin
                if (w_idx == 5'd0)      w_rdata = w_cyc[63:32];
                else if (w_idx == 5'd2) w_rdata = w_ret[63:32];
                else                    w_rdata = w_hpm_sel[63:32];
            end
            default: w_rdata = '0;
        endcase
    end

    assign bus.csr_rdata_o = w_rdata;
    assign w_wval = csr_apply(bus.csr_op_i, w_rdata, bus.csr_wdata_i);

    // mcountinhibit: unimplemented bits are forced low on write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inhibit <= '0;
        end else if (w_we && w_sel_inh) begin
            r_inhibit <= w_wval & InhMask;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < int'(HpmSz); k++) r_evt[k] <= '0;
        end else begin
            for (int k = 0; k < int'(MHPMCounterNum); k++) begin
                if (w_we && w_sel_evt && (w_hidx == 5'(k))) begin
                    r_evt[k] <= w_wval[HPM_EVT_NUM-1:0];
                end
            end
        end
    end

    // mcycle / minstret
    assign w_inc_cyc = ~r_inhibit[MCNTINH_CY] & ~stop_count_i;
    assign w_inc_ret = instr_ret_i & ~r_inhibit[MCNTINH_IR] & ~stop_count_i;

    assign w_we_cyc_lo = w_we & w_sel_lo & (w_idx == 5'd0);
    assign w_we_cyc_hi = w_we & w_sel_hi & (w_idx == 5'd0);
    assign w_we_ret_lo = w_we & w_sel_lo & (w_idx == 5'd2);
    assign w_we_ret_hi = w_we & w_sel_hi & (w_idx == 5'd2);

    cve2_counter #(.CounterWidth(64)) u_mcycle (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_inc   (w_inc_cyc),
        .i_we_lo (w_we_cyc_lo),
        .i_we_hi (w_we_cyc_hi),
        .i_wdata (w_wval),
        .o_val   (w_cyc)
    );

    cve2_counter #(.CounterWidth(64)) u_minstret (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_inc   (w_inc_ret),
        .i_we_lo (w_we_ret_lo),
        .i_we_hi (w_we_ret_hi),
        .i_wdata (w_wval),
        .o_val   (w_ret)
    );

    // mhpmcounter3 .. 3+MHPMCounterNum-1
    for (genvar k = 0; k < int'(HpmSz); k++) begin : g_hpm
        if (k < int'(MHPMCounterNum)) begin : g_impl
            logic w_inc;
            logic w_we_lo;
            logic w_we_hi;

            assign w_inc = (|(hpm_events_i & r_evt[k])) &
                           ~r_inhibit[MCNTINH_HPM0 + k] & ~stop_count_i;
            assign w_we_lo = w_we & w_sel_lo & (w_hidx == 5'(k));
            assign w_we_hi = w_we & w_sel_hi & (w_hidx == 5'(k));

            cve2_counter #(.CounterWidth(MHPMCounterWidth)) u_cnt (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .i_inc   (w_inc),
                .i_we_lo (w_we_lo),
                .i_we_hi (w_we_hi),
                .i_wdata (w_wval),
                .o_val   (w_hpm_val[k])
            );
        end else begin : g_none
            assign w_hpm_val[k] = '0;
        end
    end
endmodule

// File: tb/tb_cve2_perf_counters.sv
// Randomized bench for cve2_perf_counters against a plain
// arithmetic model of the counter CSRs, plus directed scenarios.
module tb_cve2_perf_counters;
    import cve2_perf_counters_pkg::*;

    localparam int N = 2;
    localparam int W = 40;
    localparam logic [63:0] WMASK = (64'd1 << W) - 64'd1;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       stop_count_i = 1'b0;
    logic       instr_ret_i = 1'b0;
    hpm_event_t hpm_events_i = '0;

    cve2_perf_counters_if bus ();

    cve2_perf_counters #(
        .MHPMCounterNum   (N),
        .MHPMCounterWidth (W)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .bus          (bus.slave),
        .stop_count_i (stop_count_i),
        .instr_ret_i  (instr_ret_i),
        .hpm_events_i (hpm_events_i)
    );

    always #5 clk_i = ~clk_i;

    // Reference state
    logic [63:0] m_cyc;
    logic [63:0] m_ret;
    logic [63:0] m_hpm [N];
    logic [9:0]  m_evt [N];
    logic [31:0] m_inh;
    logic [31:0] m_imask;

    int total = 0;
    int bad = 0;

    logic [11:0] addrs [20] = '{
        12'h320, 12'h321, 12'h323, 12'h324, 12'h325, 12'h33F,
        12'hB00, 12'hB01, 12'hB02, 12'hB03, 12'hB04, 12'hB05,
        12'hB1F, 12'hB80, 12'hB82, 12'hB83, 12'hB84, 12'hB85,
        12'hB9F, 12'h7C0
    };

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        m_cyc = '0;
        m_ret = '0;
        m_inh = '0;
        for (int k = 0; k < N; k++) begin
            m_hpm[k] = '0;
            m_evt[k] = '0;
        end
    endfunction

    function automatic logic m_hit(input logic [11:0] a);
        if (a == 12'h320) return 1'b1;
        if (a >= 12'h323 && a <= 12'h33F) return 1'b1;
        if (a == 12'hB00 || a == 12'hB02) return 1'b1;
        if (a == 12'hB80 || a == 12'hB82) return 1'b1;
        if (a >= 12'hB03 && a <= 12'hB1F) return 1'b1;
        if (a >= 12'hB83 && a <= 12'hB9F) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        int k;
        if (a == 12'h320) return m_inh;
        if (a >= 12'h323 && a <= 12'h33F) begin
            k = int'(a - 12'h323);
            if (k < N) return {22'd0, m_evt[k]};
            return 32'd0;
        end
        if (a == 12'hB00) return m_cyc[31:0];
        if (a == 12'hB80) return m_cyc[63:32];
        if (a == 12'hB02) return m_ret[31:0];
        if (a == 12'hB82) return m_ret[63:32];
        if (a >= 12'hB03 && a <= 12'hB1F) begin
            k = int'(a - 12'hB03);
            if (k < N) return m_hpm[k][31:0];
            return 32'd0;
        end
        if (a >= 12'hB83 && a <= 12'hB9F) begin
            k = int'(a - 12'hB83);
            if (k < N) return m_hpm[k][63:32];
            return 32'd0;
        end
        return 32'd0;
    endfunction

    // Advance the model by one clock using the current inputs
    function automatic void m_step();
        logic [11:0] a;
        logic [31:0] old;
        logic [31:0] nv;
        logic [31:0] inh;
        logic        we;
        a   = bus.csr_addr_i;
        inh = m_inh;
        we  = bus.csr_access_i && bus.csr_op_en_i && m_hit(a) &&
              (bus.csr_op_i != CSR_OP_READ);
        old = m_read(a);
        if (bus.csr_op_i == CSR_OP_WRITE)    nv = bus.csr_wdata_i;
        else if (bus.csr_op_i == CSR_OP_SET) nv = old | bus.csr_wdata_i;
        else                                 nv = old & ~bus.csr_wdata_i;

        if (we && a == 12'hB00)      m_cyc[31:0] = nv;
        else if (we && a == 12'hB80) m_cyc[63:32] = nv;
        else if (!inh[0] && !stop_count_i) m_cyc = m_cyc + 64'd1;

        if (we && a == 12'hB02)      m_ret[31:0] = nv;
        else if (we && a == 12'hB82) m_ret[63:32] = nv;
        else if (instr_ret_i && !inh[2] && !stop_count_i)
            m_ret = m_ret + 64'd1;

        for (int k = 0; k < N; k++) begin
            if (we && a == 12'hB03 + 12'(k))
                m_hpm[k][31:0] = nv;
            else if (we && a == 12'hB83 + 12'(k))
                m_hpm[k][63:32] = nv;
            else if ((|(hpm_events_i & m_evt[k])) && !inh[k+3] &&
                     !stop_count_i)
                m_hpm[k] = m_hpm[k] + 64'd1;
            m_hpm[k] = m_hpm[k] & WMASK;
        end
        for (int k = 0; k < N; k++) begin
            if (we && a == 12'h323 + 12'(k)) m_evt[k] = nv[9:0];
        end
        if (we && a == 12'h320) m_inh = nv & m_imask;
    endfunction

    // One clock: check combinational read at negedge, then advance
    task automatic cyc(input string tag);
        @(negedge clk_i);
        chk({tag, "_rd"}, 64'(bus.csr_rdata_o),
            64'(m_read(bus.csr_addr_i)));
        chk({tag, "_hit"}, 64'(bus.csr_hit_o),
            64'(m_hit(bus.csr_addr_i)));
        m_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_csr(input logic [11:0] a, input csr_op_e op,
                           input logic [31:0] d);
        bus.csr_access_i = 1'b1;
        bus.csr_op_en_i  = 1'b1;
        bus.csr_addr_i   = a;
        bus.csr_op_i     = op;
        bus.csr_wdata_i  = d;
    endtask

    task automatic idle();
        bus.csr_access_i = 1'b0;
        bus.csr_op_en_i  = 1'b0;
        bus.csr_op_i     = CSR_OP_READ;
        bus.csr_wdata_i  = '0;
    endtask

    task automatic peek(input string tag, input logic [11:0] a,
                        input logic [31:0] exp);
        idle();
        bus.csr_addr_i = a;
        #1;
        chk(tag, 64'(bus.csr_rdata_o), 64'(exp));
    endtask

    initial begin
        logic [31:0] exp_v;
        m_imask = 32'h5;
        for (int k = 0; k < N; k++) m_imask[3+k] = 1'b1;
        m_reset();
        idle();
        bus.csr_addr_i = 12'hB00;

        repeat (3) @(posedge clk_i);
        #1;
        foreach (addrs[i]) begin
            bus.csr_addr_i = addrs[i];
            #1;
            chk("rst_rd", 64'(bus.csr_rdata_o), 64'd0);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // mcycle basic
        bus.csr_addr_i = 12'hB00;
        repeat (5) cyc("boot");
        peek("mcycle5", 12'hB00, 32'd5);
        peek("mcycleh0", 12'hB80, 32'd0);

        // carry from bit 31
        set_csr(12'hB00, CSR_OP_WRITE, 32'hFFFF_FFFF);
        cyc("wlo");
        set_csr(12'hB80, CSR_OP_WRITE, 32'h0);
        cyc("whi");
        idle();
        cyc("c1");
        peek("carry_lo", 12'hB00, 32'h0);
        cyc("c2");
        peek("carry_hi", 12'hB80, 32'h1);

        // write beats do not also increment
        set_csr(12'hB00, CSR_OP_WRITE, 32'h100);
        cyc("wp");
        peek("wp1", 12'hB00, 32'h100);
        cyc("wp_a");
        peek("wp2", 12'hB00, 32'h101);

        // inhibit via SET, release minstret via CLEAR
        set_csr(12'h320, CSR_OP_SET, 32'h5);
        cyc("inh_set");
        idle();
        instr_ret_i = 1'b1;
        bus.csr_addr_i = 12'hB02;
        repeat (10) cyc("inh");
        peek("inh_cyc", 12'hB00, 32'h102);
        peek("inh_ret", 12'hB02, 32'h0);
        set_csr(12'h320, CSR_OP_CLEAR, 32'h4);
        cyc("inh_clr");
        idle();
        repeat (3) cyc("ret");
        peek("ret3", 12'hB02, 32'd3);
        peek("cyc_frozen", 12'hB00, 32'h102);
        instr_ret_i = 1'b0;

        // mhpmcounter3 on JUMP, 40-bit width
        set_csr(12'h323, CSR_OP_WRITE, 32'h4);
        cyc("evt");
        idle();
        repeat (3) begin
            hpm_events_i = 10'(1 << HPM_EVT_JUMP);
            cyc("jmp");
            hpm_events_i = '0;
            cyc("jmp0");
        end
        hpm_events_i = 10'(1 << HPM_EVT_LOAD);
        cyc("load");
        hpm_events_i = '0;
        peek("hpm3", 12'hB03, 32'd3);
        set_csr(12'hB83, CSR_OP_WRITE, 32'hFFFF_FFFF);
        cyc("hpmh");
        peek("hpm3h", 12'hB83, 32'hFF);
        peek("hpm3lo", 12'hB03, 32'd3);
        peek("evt3", 12'h323, 32'h4);

        // unimplemented counter
        bus.csr_addr_i = 12'hB07;
        #1;
        chk("unimp_hit", 64'(bus.csr_hit_o), 64'd1);
        chk("unimp_rd", 64'(bus.csr_rdata_o), 64'd0);
        set_csr(12'hB07, CSR_OP_WRITE, 32'h123);
        cyc("unimp_w");
        peek("unimp_rd2", 12'hB07, 32'd0);

        // stop_count freezes mcycle
        set_csr(12'h320, CSR_OP_CLEAR, 32'h1);
        cyc("run");
        idle();
        cyc("run1");
        exp_v = m_cyc[31:0];
        stop_count_i = 1'b1;
        bus.csr_addr_i = 12'hB00;
        repeat (4) cyc("stop");
        peek("stop", 12'hB00, exp_v);
        stop_count_i = 1'b0;
        cyc("unstop");
        peek("unstop", 12'hB00, exp_v + 32'd1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.csr_addr_i   = addrs[$urandom_range(0, 19)];
            bus.csr_op_i     = csr_op_e'($urandom_range(0, 3));
            bus.csr_access_i = ($urandom_range(0, 3) != 0);
            bus.csr_op_en_i  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0)
                bus.csr_wdata_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                bus.csr_wdata_i = $urandom;
            hpm_events_i = 10'($urandom);
            instr_ret_i  = 1'($urandom);
            stop_count_i = ($urandom_range(0, 15) == 0);
            cyc("rnd");
        end
        idle();
        stop_count_i = 1'b0;
        instr_ret_i  = 1'b0;
        hpm_events_i = '0;

        // asynchronous reset mid-run
        bus.csr_addr_i = 12'hB00;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_cyc", 64'(bus.csr_rdata_o), 64'd0);
        bus.csr_addr_i = 12'h323;
        #1;
        chk("arst_evt", 64'(bus.csr_rdata_o), 64'd0);
        m_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.csr_addr_i = addrs[$urandom_range(0, 19)];
            cyc("post");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
